// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// UART_TX_PARITY_EN adds the PARITY frame state.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte queue for the UART transmitter; pushes are refused while
// full even if a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q == DEPTH_C);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_ptr_q];
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Queued UART transmitter: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// state | meaning: IDLE line high / START start bit / DATA 8 bits LSB first / PARITY even parity / STOP stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 tx_q;
    logic                 line_d;
    logic                 bit_tc;

    logic                 fifo_pop;
    logic [7:0]           fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FCW-1:0]       fifo_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_valid),
        .i_wdata (i_data),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign bit_tc   = (cnt_q == '0);
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_tc));
    assign o_ready  = !fifo_full;
    assign o_busy   = (state_q != ST_IDLE) || (fifo_count != '0);
    assign o_tx     = tx_q;

    // o_tx is registered from the state, so the line trails the FSM by one cycle
    always_comb begin
        line_d = LINE_IDLE;
        case (state_q)
            ST_START:  line_d = ~LINE_IDLE;
            ST_DATA:   line_d = data_q[idx_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_d = ^data_q;
`endif
            ST_STOP:   line_d = LINE_IDLE;
            default:   line_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= LINE_IDLE;
        end else begin
            tx_q <= line_d;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        data_q  <= fifo_rdata;
                        idx_q   <= '0;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tc) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_tc) begin
                        cnt_q <= CNT_LOAD;
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tc) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tc) begin
                        if (!fifo_empty) begin
                            data_q  <= fifo_rdata;
                            idx_q   <= '0;
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLKS_PER_BIT=8, FIFO_DEPTH=4) with a behavioural
// line receiver for loopback; define UART_TX_PARITY_EN to cover the parity build.
module tb_uart_tx;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic       exp_bits[$];
    logic [7:0] rx_q[$];
    int         rx_err = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready),
        .o_tx    (tx),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_frame(input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back(^b);
`endif
        exp_bits.push_back(1'b1);
    endtask

    // Starts sampling at the current cycle, which must be the first start-bit cycle
    task automatic check_stream(input string tag);
        int bad = 0;
        foreach (exp_bits[i]) begin
            for (int c = 0; c < CPB; c++) begin
                if (tx !== exp_bits[i]) bad++;
                tick();
            end
        end
        exp_bits.delete();
        check(tag, bad, 0);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    // Behavioural receiver: mid-bit sampling off the falling edge of the start bit
    always begin
        logic [7:0] rb;
        @(negedge clk);
        if (tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rb[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            if (tx !== ^rb) rx_err++;
`endif
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) rx_err++;
            rx_q.push_back(rb);
        end
    end

    initial begin
        int n;
        int lows;
        logic [7:0] burst [5];
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b1);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_tx", tx, 1'b1);

        // single byte 0x55 from idle
        rx_q.delete();
        data  = 8'h55;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("lat_e0", tx, 1'b1);
        check("busy_acc", busy, 1'b1);
        tick();
        check("lat_e1", tx, 1'b1);
        tick();
        check("lat_e2", tx, 1'b0);
        add_frame(8'h55);
        check_stream("frame55");
        check("end55_tx", tx, 1'b1);
        check("end55_busy", busy, 1'b0);
        check("rx55_n", rx_q.size(), 1);
        if (rx_q.size() == 1) check("rx55", rx_q[0], 8'h55);

`ifdef UART_TX_PARITY_EN
        // even parity: 0x55 has four ones, 0x07 has three
        data  = 8'h55;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        repeat (9 * CPB) tick();
        check("par55", tx, 1'b0);
        wait_idle("par55_idle", 200);
        data  = 8'h07;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        repeat (9 * CPB) tick();
        check("par07", tx, 1'b1);
        wait_idle("par07_idle", 200);
        repeat (4) tick();
`endif

        // back-to-back frames with no gap
        rx_q.delete();
        data  = 8'hA1;
        valid = 1'b1;
        tick();
        data  = 8'hB2;
        tick();
        valid = 1'b0;
        check("b2b_e1", tx, 1'b1);
        tick();
        add_frame(8'hA1);
        add_frame(8'hB2);
        check_stream("b2b_stream");
        check("b2b_end_tx", tx, 1'b1);
        check("b2b_end_busy", busy, 1'b0);

        // fill the queue, then hold a rejected push across the full-with-pop cycle
        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            data  = burst[i];
            valid = 1'b1;
            tick();
        end
        check("full_ready", ready, 1'b0);
        data = 8'h66;
        n = 0;
        while (!ready && n < 300) begin
            tick();
            n++;
        end
        valid = 1'b0;
        check("free_ready", ready, 1'b1);
        check("free_delay", n, FRAME_BITS * CPB - 3);
        wait_idle("burst_idle", 2000);
        check("burst_n", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check("burst_byte", rx_q[i], burst[i]);
        end

        // reset during data bit 3 of 0x07 with two bytes still queued
        repeat (4) tick();
        data  = 8'h07;
        valid = 1'b1;
        tick();
        data  = 8'hAA;
        tick();
        data  = 8'hBB;
        tick();
        valid = 1'b0;
        repeat (34) tick();
        check("rst_pre_bit3", tx, 1'b0);
        rst_n = 1'b0;
        valid = 1'b1;
        data  = 8'hEE;
        tick();
        rst_n = 1'b1;
        valid = 1'b0;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", ready, 1'b1);
        lows = 0;
        repeat (200) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("midrst_quiet", lows, 0);
        check("midrst_busy2", busy, 1'b0);

        // loopback through the receiver model
        rx_q.delete();
        rx_err = 0;
        data  = 8'h00;
        valid = 1'b1;
        tick();
        data  = 8'hFF;
        tick();
        data  = 8'h3C;
        tick();
        valid = 1'b0;
        wait_idle("loop_idle", 1000);
        check("loop_n", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("loop_00", rx_q[0], 8'h00);
            check("loop_ff", rx_q[1], 8'hFF);
            check("loop_3c", rx_q[2], 8'h3C);
        end
        check("loop_frame_err", rx_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, i_clk cycles per serial bit (min 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte queue entries (power of two, min 2).
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_data  input  8  byte to transmit.
REQ-006 SHALL have port i_valid  input  1  i_data valid this cycle.
REQ-007 SHALL have port o_ready  output  1  queue can accept a byte this cycle.
REQ-008 SHALL have port o_tx  output  1  serial line, idle high, registered.
REQ-009 SHALL have port o_busy  output  1  frame in progress or queue non-empty.

Function
REQ-010 SHALL accept a byte on a rising edge where i_valid=1 and o_ready=1; i_data ignored otherwise.
REQ-011 SHALL drive o_ready=1 iff queue count < FIFO_DEPTH; combinational from count, not from i_valid.
REQ-012 SHALL, when full, ignore i_valid even if a pop occurs in the same cycle; a freed slot is visible the next cycle.
REQ-013 SHALL, when neither full nor empty, perform simultaneous push and pop with count unchanged.
REQ-014 SHALL implement states IDLE, START, DATA, STOP (PARITY added per REQ-024).
REQ-015 SHALL, in IDLE with queue non-empty, pop the head byte, clear the bit counter and enter START.
REQ-016 SHALL hold each serial bit on o_tx for exactly CLKS_PER_BIT cycles.
REQ-017 SHALL frame as start bit 0, 8 data bits LSB first, stop bit 1.
REQ-018 SHALL, at the end of STOP, pop and enter START directly when the queue is non-empty (zero idle cycles between frames); otherwise enter IDLE.
REQ-019 SHALL drive o_tx low on the 2nd rising edge after the accepting edge when idle and the queue is empty.
REQ-020 SHALL keep o_tx=1 in IDLE.
REQ-021 SHALL use a bit-period counter of width clog2(CLKS_PER_BIT) and a 3-bit data index wrapping 7->0 at DATA exit.
REQ-022 SHALL drive o_busy=0 only in IDLE with the queue empty.

Reset
REQ-023 SHALL, on a rising edge with i_rst_n=0, regardless of state (including mid-frame): o_tx=1, o_busy=0, state IDLE, counters 0, queue emptied (o_ready=1), queued bytes discarded, i_valid ignored that cycle.

Configuration
REQ-024 SHALL, with macro UART_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP transmitting one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bits.
REQ-025 SHALL, without UART_TX_PARITY_EN, contain no parity logic; frame = 10 bits, DATA goes directly to STOP.

Structure
REQ-026 SHALL place the state enum, DATA_BITS=8 and the line-idle level constant in shared package uart_pkg, also used by the receiver.
REQ-027 SHALL implement the byte queue as sub-module uart_tx_fifo (sync FIFO, push/pop/full/empty/count, same clock and reset).

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-028 SHALL cover: push 0x55 while idle -> o_tx low 2 edges later, line pattern 0,1,0,1,0,1,0,1,0,1 each 8 cycles, frame 80 cycles, o_busy 0 afterwards.
REQ-029 SHALL cover, with UART_TX_PARITY_EN: 0x55 -> parity 0, 88-cycle frame; 0x07 -> parity 1.
REQ-030 SHALL cover: push 0xA1,0xB2 back-to-back -> second start bit begins the cycle after first stop bit ends, 160 contiguous cycles.
REQ-031 SHALL cover: 5 pushes on consecutive cycles while idle -> first popped; remaining 4 fill queue; o_ready=0 during the 6th attempt; full-with-pop push rejected per REQ-012.
REQ-032 SHALL cover: assert i_rst_n=0 for one cycle during data bit 3 -> o_tx=1 next edge, o_busy=0, queued bytes never transmitted.
REQ-033 SHALL cover: loopback o_tx into the receiver for bytes 0x00, 0xFF, 0x3C -> identical bytes received.
